// File: rtl/uart_cmd_ctrl.sv
// uart_cmd_ctrl: framed UART command parser with a two-byte status/data response
module uart_cmd_ctrl #(
  parameter logic [7:0] SYNC_BYTE      = 8'hA5,
  parameter int         TIMEOUT_CYCLES = 50000,
  parameter logic [7:0] CFG_RESET      = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_uart_data,
  input  logic       rx_uart_valid,
  input  logic       tx_uart_busy,
  output logic [7:0] tx_uart_data,
  output logic       tx_uart_valid,
  output logic       start_write_frame,
  output logic [7:0] cfg_reg,
  output logic [7:0] err_cnt
);
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  typedef enum logic [3:0] {IDLE, GET_CMD, GET_ARG, GET_CHK, EXEC, TX0, TX0_GAP, TX1, TX1_GAP} state_t;
  state_t state, state_nxt;
  logic [7:0] cmd_q, arg_q, chk_q, status_q, data_q, tx_q, cfg_q, err_q;
  logic [7:0] resp_status, resp_data, tx_byte;
  logic [TW-1:0] timer;
  logic in_get, timeout, exec, strobe, chk_ok, cmd_ok, err_inc;
  assign in_get      = state inside {GET_CMD, GET_ARG, GET_CHK};
  assign timeout     = in_get && !rx_uart_valid && timer == TW'(TIMEOUT_CYCLES - 1);
  assign exec        = state == EXEC;
  assign strobe      = state inside {TX0, TX1} && !tx_uart_busy;
  assign tx_byte     = state == TX0 ? status_q : data_q;
  assign chk_ok      = (cmd_q ^ arg_q) == chk_q;
  assign cmd_ok      = cmd_q inside {[8'h01:8'h04]};
  assign err_inc     = (exec && !(chk_ok && cmd_ok)) || timeout;
  assign resp_status = chk_ok && cmd_ok ? 8'h06 : 8'h15;
  assign resp_data   = !chk_ok ? 8'hFF :
                       cmd_q == 8'h01 ? 8'h01 :
                       cmd_q == 8'h02 ? arg_q :
                       cmd_q == 8'h03 ? cfg_q :
                       cmd_q == 8'h04 ? err_q : cmd_q;
  // outputs are forced to their reset values for as long as rst is held
  assign tx_uart_valid     = !rst && strobe;
  assign tx_uart_data      = rst ? 8'h00 : strobe ? tx_byte : tx_q;
  assign start_write_frame = !rst && exec && chk_ok && cmd_q == 8'h01;
  assign cfg_reg           = rst ? CFG_RESET : cfg_q;
  assign err_cnt           = rst ? 8'h00 : err_q;
  // state register
  always_ff @(posedge clk) begin
    state <= rst ? IDLE : state_nxt;
  end
  // next-state logic: frame reception, one-clock execute, then two gapped transmit strobes
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    state_nxt = rx_uart_valid && rx_uart_data == SYNC_BYTE ? GET_CMD : IDLE;
      GET_CMD: state_nxt = rx_uart_valid ? GET_ARG : timeout ? IDLE : GET_CMD;
      GET_ARG: state_nxt = rx_uart_valid ? GET_CHK : timeout ? IDLE : GET_ARG;
      GET_CHK: state_nxt = rx_uart_valid ? EXEC : timeout ? IDLE : GET_CHK;
      EXEC:    state_nxt = TX0;
      TX0:     state_nxt = strobe ? TX0_GAP : TX0;
      TX0_GAP: state_nxt = TX1;
      TX1:     state_nxt = strobe ? TX1_GAP : TX1;
      TX1_GAP: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end
  // datapath: byte capture, inter-byte timer, command side effects and held tx byte
  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_q    <= 8'h00;
      arg_q    <= 8'h00;
      chk_q    <= 8'h00;
      status_q <= 8'h00;
      data_q   <= 8'h00;
      tx_q     <= 8'h00;
      cfg_q    <= CFG_RESET;
      err_q    <= 8'h00;
      timer    <= '0;
    end else begin
      timer <= in_get && !rx_uart_valid && !timeout ? timer + TW'(1) : '0;
      if (rx_uart_valid && state == GET_CMD) cmd_q <= rx_uart_data;
      if (rx_uart_valid && state == GET_ARG) arg_q <= rx_uart_data;
      if (rx_uart_valid && state == GET_CHK) chk_q <= rx_uart_data;
      if (exec) begin
        status_q <= resp_status;
        data_q   <= resp_data;
      end
      if (exec && chk_ok && cmd_q == 8'h02) cfg_q <= arg_q;
      if (err_inc && err_q != 8'hFF) err_q <= err_q + 8'h01;
      if (strobe) tx_q <= tx_byte;
    end
  end
endmodule

// File: doc/uart_cmd_ctrl.md
UART_CMD_CTRL -- requirements
Module: uart_cmd_ctrl

Interface
REQ-001 Parameter SYNC_BYTE, default 8'hA5, frame start marker.
REQ-002 Parameter TIMEOUT_CYCLES, default 50000, maximum idle clocks allowed between bytes inside a frame.
REQ-003 Parameter CFG_RESET, default 8'h00, reset value of cfg_reg.
REQ-004 Port clk  input  1  sole clock; all logic on rising edge.
REQ-005 Port rst  input  1  synchronous, active-high reset.
REQ-006 Port rx_uart_data  input  8  received byte from UART receiver.
REQ-007 Port rx_uart_valid  input  1  single-cycle strobe; rx_uart_data valid.
REQ-008 Port tx_uart_busy  input  1  UART transmitter busy.
REQ-009 Port tx_uart_data  output  8  byte to transmit.
REQ-010 Port tx_uart_valid  output  1  single-cycle write strobe to transmitter.
REQ-011 Port start_write_frame  output  1  single-cycle frame-start pulse.
REQ-012 Port cfg_reg  output  8  configuration register written over UART.
REQ-013 Port err_cnt  output  8  saturating protocol-error counter.

Function
REQ-014 Frame format SHALL be: SYNC_BYTE, CMD, ARG, CHK, in that order, with CHK = CMD xor ARG.
REQ-015 States SHALL be IDLE, GET_CMD, GET_ARG, GET_CHK, EXEC, TX0, TX0_GAP, TX1, TX1_GAP.
REQ-016 IDLE: a byte equal to SYNC_BYTE -> GET_CMD; any other byte is discarded silently, with no error count.
REQ-017 GET_CMD/GET_ARG/GET_CHK: each rx_uart_valid latches the byte and advances one state; GET_CHK -> EXEC.
REQ-018 Inter-byte timer: cleared on entry to GET_CMD and on every accepted byte; incremented each clock in GET_CMD/GET_ARG/GET_CHK without a byte.
REQ-019 Timeout: when the timer reaches TIMEOUT_CYCLES-1 without a byte, go to IDLE, increment err_cnt, and send no response.
REQ-020 EXEC lasts exactly one clock and selects the response (status, data):
- CHK mismatch: (8'h15, 8'hFF); err_cnt++; no command side effect.
- CMD 8'h01: start_write_frame=1 for this clock only; (8'h06, 8'h01).
- CMD 8'h02: cfg_reg <= ARG on this edge; (8'h06, ARG).
- CMD 8'h03: (8'h06, cfg_reg).
- CMD 8'h04: (8'h06, err_cnt value before any increment this clock).
- any other CMD: (8'h15, CMD); err_cnt++.
REQ-021 EXEC SHALL go to TX0.
REQ-022 TX0: when tx_uart_busy=0, drive tx_uart_valid=1 with the status byte for one clock and go to TX0_GAP; otherwise hold.
REQ-023 TX0_GAP: wait one clock unconditionally, then go to TX1, so the transmitter's busy flag has time to assert.
REQ-024 TX1/TX1_GAP: same as TX0/TX0_GAP for the data byte; TX1_GAP -> IDLE.
REQ-025 rx_uart_valid in EXEC or any TX state SHALL be ignored, with no error count.
REQ-026 tx_uart_valid SHALL never be asserted while tx_uart_busy=1.
REQ-027 tx_uart_data SHALL hold its value from the strobe clock until the next strobe.
REQ-028 err_cnt SHALL saturate at 8'hFF.
REQ-029 Latency: start_write_frame SHALL assert exactly 1 clock after the clock on which the CHK byte is strobed.
REQ-030 A SYNC_BYTE value received inside a frame SHALL be treated as ordinary data.

Reset
REQ-031 While rst=1, regardless of state, outputs SHALL be: state IDLE; tx_uart_valid=0; tx_uart_data=0; start_write_frame=0; cfg_reg=CFG_RESET; err_cnt=0; timer=0.
REQ-032 Reset asserted mid-frame or mid-transmit SHALL abort without emitting a further tx strobe; the first clock after release SHALL be IDLE.

Verification
REQ-033 Bytes A5 01 00 01 -> one start_write_frame pulse 1 clock after CHK; TX bytes 06, 01.
REQ-034 A5 02 5C 5E, then A5 03 00 03 -> cfg_reg=5C; TX 06 5C, then 06 5C.
REQ-035 A5 01 00 00 (bad CHK) -> no pulse; TX 15 FF; then A5 04 00 04 -> TX 06 01.
REQ-036 A5 01, then TIMEOUT_CYCLES idle clocks -> IDLE, err_cnt=1, no TX; a following good frame is accepted.
REQ-037 Hold tx_uart_busy=1 for 100 clocks during TX0 -> no strobe until busy falls; strobe never coincides with busy=1.
REQ-038 rst pulse during GET_ARG and during TX1 -> outputs at reset values, no strobe; the next frame is processed normally.
